// File: rtl/rx_mac.sv
// rtl/rx_mac.sv - Ethernet receive MAC: preamble/SFD strip, FCS check, AXI-Stream payload out
//
// Purpose:
//   Consumes the byte stream from the RGMII layer, strips the preamble and
//   SFD, runs CRC-32 over everything after the SFD and checks the minimum
//   frame length. The payload is forwarded through a 5-byte delay line so
//   that the FCS never reaches the output; the final payload byte carries
//   tlast, and tuser flags a frame the RX FIFO should drop.
//
// Ports:
//   clk                 MAC clock, rising edge
//   reset               synchronous, active-high
//   rgmii_mac_rx_data   received byte
//   rgmii_mac_rx_dv     frame valid (covers preamble too)
//   rgmii_mac_rx_er     PHY error on the current byte
//   mii_select          1 = MII (byte on alternate dv-high cycles), 0 = GMII
//   m_rx_axis_tdata     payload byte
//   m_rx_axis_tvalid    one-cycle strobe per payload byte, no backpressure
//   m_rx_axis_tlast     final payload byte
//   m_rx_axis_tuser     bad frame, valid with tlast
//   rx_frame_good       pulse with a tlast beat that has tuser = 0
//   rx_frame_bad        pulse with a tlast beat that has tuser = 1

module rx_mac #(
    parameter int MIN_FRAME = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rgmii_mac_rx_data,
    input  logic       rgmii_mac_rx_dv,
    input  logic       rgmii_mac_rx_er,
    input  logic       mii_select,
    output logic [7:0] m_rx_axis_tdata,
    output logic       m_rx_axis_tvalid,
    output logic       m_rx_axis_tlast,
    output logic       m_rx_axis_tuser,
    output logic       rx_frame_good,
    output logic       rx_frame_bad
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] COUNT_MAX   = 11'd2047;
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME);
    localparam logic [10:0] HOLD_BYTES  = 11'd5;
    localparam logic [2:0]  DL_DEPTH    = 3'd5;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;

    // Reflected CRC-32, one byte per call, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc_in,
                                             input logic [7:0]  data_in);
        logic [31:0] r;
        r = crc_in ^ {24'd0, data_in};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic            phase_q, phase_d;
    logic            dv_prev_q, dv_prev_d;
    logic [31:0]     crc_q, crc_d;
    logic [10:0]     count_q, count_d;
    logic            err_q, err_d;
    logic [4:0][7:0] dl_q, dl_d;
    logic [2:0]      fill_q, fill_d;

    logic [7:0]      tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic            tuser_q, tuser_d;
    logic            good_q, good_d;
    logic            bad_q, bad_d;

    logic            byte_qual;
    logic            frame_bad;

    always_comb begin
        state_d   = state_q;
        phase_d   = 1'b0;
        dv_prev_d = rgmii_mac_rx_dv;
        crc_d     = crc_q;
        count_d   = count_q;
        err_d     = err_q;
        dl_d      = dl_q;
        fill_d    = fill_q;
        tdata_d   = tdata_q;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        good_d    = 1'b0;
        bad_d     = 1'b0;

        // In MII mode the phase toggle starts at 0 on the first dv-high
        // cycle, so that cycle and every second one after it carry a byte.
        byte_qual = rgmii_mac_rx_dv & (~mii_select | ~phase_q);
        if (rgmii_mac_rx_dv) begin
            phase_d = ~phase_q;
        end

        frame_bad = err_q | (count_q < MIN_LEN) | (crc_q != CRC_RESIDUE);

        case (state_q)
            ST_IDLE: begin
                // dv already high here means we came out of reset mid-frame:
                // discard the rest of it rather than forward a fragment.
                if (rgmii_mac_rx_dv) begin
                    state_d = dv_prev_q ? ST_DROP : ST_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                if (!rgmii_mac_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (byte_qual) begin
                    if (rgmii_mac_rx_er) begin
                        state_d = ST_DROP;
                    end else if (rgmii_mac_rx_data == SFD_BYTE) begin
                        state_d = ST_PAYLOAD;
                        crc_d   = CRC_INIT;
                        count_d = 11'd0;
                        err_d   = 1'b0;
                        fill_d  = 3'd0;
                        dl_d    = '0;
                    end else if (rgmii_mac_rx_data != PRE_BYTE) begin
                        state_d = ST_DROP;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!rgmii_mac_rx_dv) begin
                    // Finalise: the delay line still holds the last payload
                    // byte (oldest) plus the four FCS bytes.
                    state_d = ST_IDLE;
                    if (count_q >= HOLD_BYTES) begin
                        tvalid_d = 1'b1;
                        tdata_d  = dl_q[4];
                        tlast_d  = 1'b1;
                        tuser_d  = frame_bad;
                        good_d   = ~frame_bad;
                        bad_d    = frame_bad;
                    end
                    dl_d   = '0;
                    fill_d = 3'd0;
                    err_d  = 1'b0;
                end else if (byte_qual) begin
                    crc_d   = crc_next(crc_q, rgmii_mac_rx_data);
                    count_d = (count_q == COUNT_MAX) ? count_q : count_q + 11'd1;
                    err_d   = err_q | rgmii_mac_rx_er;
                    dl_d    = {dl_q[3:0], rgmii_mac_rx_data};
                    if (fill_q == DL_DEPTH) begin
                        // Full line: the byte falling out is five bytes old,
                        // so it can no longer be part of the FCS.
                        tvalid_d = 1'b1;
                        tdata_d  = dl_q[4];
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
            end

            ST_DROP: begin
                if (!rgmii_mac_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            dv_prev_q <= 1'b1;
            crc_q     <= CRC_INIT;
            count_q   <= 11'd0;
            err_q     <= 1'b0;
            dl_q      <= '0;
            fill_q    <= 3'd0;
            tdata_q   <= 8'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            dv_prev_q <= dv_prev_d;
            crc_q     <= crc_d;
            count_q   <= count_d;
            err_q     <= err_d;
            dl_q      <= dl_d;
            fill_q    <= fill_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    assign m_rx_axis_tdata  = tdata_q;
    assign m_rx_axis_tvalid = tvalid_q;
    assign m_rx_axis_tlast  = tlast_q;
    assign m_rx_axis_tuser  = tuser_q;
    assign rx_frame_good    = good_q;
    assign rx_frame_bad     = bad_q;

endmodule

// File: tb/tb_rx_mac.sv
// tb/tb_rx_mac.sv - directed testbench for rx_mac

module tb_rx_mac;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic       mii = 1'b0;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser, fgood, fbad;

    rx_mac #(.MIN_FRAME(64)) dut (
        .clk               (clk),
        .reset             (reset),
        .rgmii_mac_rx_data (rx_data),
        .rgmii_mac_rx_dv   (rx_dv),
        .rgmii_mac_rx_er   (rx_er),
        .mii_select        (mii),
        .m_rx_axis_tdata   (tdata),
        .m_rx_axis_tvalid  (tvalid),
        .m_rx_axis_tlast   (tlast),
        .m_rx_axis_tuser   (tuser),
        .rx_frame_good     (fgood),
        .rx_frame_bad      (fbad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx[$];
    logic       er_v[$];
    int         t_pay0;

    logic [7:0] bd[$];
    int         bc[$];
    int         n_last, last_pos, n_good, n_bad, stray;
    logic       last_user;

    // Beat logger; also counts any qualifier seen without its tvalid/tlast.
    always @(negedge clk) begin
        if (tvalid) begin
            bd.push_back(tdata);
            bc.push_back(cyc);
            if (tlast) begin
                n_last++;
                last_pos  = int'(bd.size()) - 1;
                last_user = tuser;
            end
        end
        if (fgood) begin
            n_good++;
            if (!(tvalid && tlast && !tuser)) stray++;
        end
        if (fbad) begin
            n_bad++;
            if (!(tvalid && tlast && tuser)) stray++;
        end
        if (!tvalid && (tlast || tuser)) stray++;
    end

    task automatic clear_log();
        bd.delete();
        bc.delete();
        n_last = 0; n_good = 0; n_bad = 0; stray = 0;
        last_pos = -1; last_user = 1'b0;
    endtask

    // Preamble + SFD + payload (base+i) + optional FCS (first bit optionally flipped).
    task automatic build(input int plen, input int base, input bit add_fcs, input bit flip);
        logic [31:0] c;
        logic [7:0]  b;
        tx.delete();
        er_v.delete();
        for (int i = 0; i < 7; i++) begin tx.push_back(8'h55); er_v.push_back(1'b0); end
        tx.push_back(8'hD5); er_v.push_back(1'b0);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < plen; i++) begin
            b = 8'(base + i);
            tx.push_back(b);
            er_v.push_back(1'b0);
            c = c ^ {24'd0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        if (add_fcs) begin
            c = ~c;
            if (flip) c[0] = ~c[0];
            for (int k = 0; k < 4; k++) begin tx.push_back(c[8*k +: 8]); er_v.push_back(1'b0); end
        end
    endtask

    task automatic send(input int gap);
        int reps;
        reps = mii ? 2 : 1;
        for (int i = 0; i < tx.size(); i++) begin
            for (int r = 0; r < reps; r++) begin
                @(negedge clk);
                rx_dv = 1'b1; rx_data = tx[i]; rx_er = er_v[i];
                if (i == 8 && r == 0) t_pay0 = cyc + 1;
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_dv = 1'b0; rx_er = 1'b0; rx_data = 8'd0;
        end
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({tdata, tvalid, tlast, tuser, fgood, fbad} !== 13'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", {tdata, tvalid, tlast, tuser, fgood, fbad});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_gmii();
        int mm, gaps;
        clear_log(); mii = 1'b0;
        build(60, 0, 1, 0); send(1); settle();
        checks++; if (bd.size() !== 60) begin errors++; $display("FAIL good_beats got %0d want 60", bd.size()); end
        mm = 0; for (int i = 0; i < bd.size(); i++) if (bd[i] !== 8'(i)) mm++;
        checks++; if (mm !== 0) begin errors++; $display("FAIL good_data got %0d bad bytes want 0", mm); end
        checks++; if (n_last !== 1 || last_pos !== 59) begin errors++; $display("FAIL good_tlast got n=%0d pos=%0d want n=1 pos=59", n_last, last_pos); end
        checks++; if (last_user !== 1'b0) begin errors++; $display("FAIL good_tuser got %b want 0", last_user); end
        checks++; if (n_good !== 1 || n_bad !== 0) begin errors++; $display("FAIL good_pulses got g=%0d b=%0d want g=1 b=0", n_good, n_bad); end
        checks++; if (stray !== 0) begin errors++; $display("FAIL good_stray got %0d want 0", stray); end
        gaps = 0; for (int i = 1; i < bc.size(); i++) if (bc[i] - bc[i-1] != 1) gaps++;
        checks++; if (gaps !== 0) begin errors++; $display("FAIL gmii_continuous got %0d gaps want 0", gaps); end
        checks++; if (bc.size() == 0 || bc[0] !== t_pay0 + 5) begin errors++; $display("FAIL first_latency got %0d want %0d", (bc.size() == 0) ? -1 : bc[0], t_pay0 + 5); end
    endtask

    task automatic test_bad_fcs();
        int mm;
        clear_log(); mii = 1'b0;
        build(60, 0, 1, 1); send(1); settle();
        mm = 0; for (int i = 0; i < bd.size(); i++) if (bd[i] !== 8'(i)) mm++;
        checks++; if (bd.size() !== 60 || mm !== 0) begin errors++; $display("FAIL fcs_data got n=%0d mm=%0d want n=60 mm=0", bd.size(), mm); end
        checks++; if (n_last !== 1 || last_pos !== 59 || last_user !== 1'b1) begin errors++; $display("FAIL fcs_tuser got n=%0d pos=%0d u=%b want 1 59 1", n_last, last_pos, last_user); end
        checks++; if (n_good !== 0 || n_bad !== 1 || stray !== 0) begin errors++; $display("FAIL fcs_pulses got g=%0d b=%0d s=%0d want 0 1 0", n_good, n_bad, stray); end
    endtask

    task automatic test_runt();
        int mm;
        clear_log(); mii = 1'b0;
        build(16, 0, 1, 0); send(1); settle();
        mm = 0; for (int i = 0; i < bd.size(); i++) if (bd[i] !== 8'(i)) mm++;
        checks++; if (bd.size() !== 16 || mm !== 0) begin errors++; $display("FAIL runt_data got n=%0d mm=%0d want n=16 mm=0", bd.size(), mm); end
        checks++; if (n_last !== 1 || last_user !== 1'b1 || n_bad !== 1 || n_good !== 0) begin errors++; $display("FAIL runt_tuser got n=%0d u=%b b=%0d g=%0d want 1 1 1 0", n_last, last_user, n_bad, n_good); end
        clear_log();
        build(3, 8'h40, 0, 0); send(1); settle();
        checks++; if (bd.size() !== 0 || n_good + n_bad !== 0) begin errors++; $display("FAIL short3_silent got beats=%0d pulses=%0d want 0 0", bd.size(), n_good + n_bad); end
    endtask

    task automatic test_errors();
        int mm;
        clear_log(); mii = 1'b0;
        build(60, 0, 1, 0); er_v[8 + 30] = 1'b1; send(1); settle();
        mm = 0; for (int i = 0; i < bd.size(); i++) if (bd[i] !== 8'(i)) mm++;
        checks++; if (bd.size() !== 60 || mm !== 0) begin errors++; $display("FAIL er_data got n=%0d mm=%0d want n=60 mm=0", bd.size(), mm); end
        checks++; if (last_user !== 1'b1 || n_bad !== 1 || n_good !== 0) begin errors++; $display("FAIL er_tuser got u=%b b=%0d g=%0d want 1 1 0", last_user, n_bad, n_good); end
        clear_log();
        build(60, 0, 1, 0); er_v[3] = 1'b1; send(1); settle();
        checks++; if (bd.size() !== 0 || n_last !== 0) begin errors++; $display("FAIL pre_er_drop got beats=%0d last=%0d want 0 0", bd.size(), n_last); end
        clear_log();
        build(60, 0, 1, 0); tx[4] = 8'h5D; send(1); settle();
        checks++; if (bd.size() !== 0 || n_last !== 0) begin errors++; $display("FAIL pre_5d_drop got beats=%0d last=%0d want 0 0", bd.size(), n_last); end
        clear_log();
        build(60, 0, 1, 0); send(1); settle();
        checks++; if (bd.size() !== 60 || n_good !== 1 || last_user !== 1'b0) begin errors++; $display("FAIL after_drop_good got n=%0d g=%0d u=%b want 60 1 0", bd.size(), n_good, last_user); end
    endtask

    task automatic test_mii();
        int mm, gaps;
        clear_log(); mii = 1'b1;
        build(60, 0, 1, 0); send(1); settle();
        mm = 0; for (int i = 0; i < bd.size(); i++) if (bd[i] !== 8'(i)) mm++;
        checks++; if (bd.size() !== 60 || mm !== 0) begin errors++; $display("FAIL mii_data got n=%0d mm=%0d want n=60 mm=0", bd.size(), mm); end
        gaps = 0; for (int i = 1; i + 1 < bc.size(); i++) if (bc[i] - bc[i-1] != 2) gaps++;
        checks++; if (gaps !== 0) begin errors++; $display("FAIL mii_spacing got %0d bad gaps want 0", gaps); end
        checks++; if (last_user !== 1'b0 || n_good !== 1 || n_bad !== 0 || last_pos !== 59) begin errors++; $display("FAIL mii_good got u=%b g=%0d b=%0d pos=%0d want 0 1 0 59", last_user, n_good, n_bad, last_pos); end
        mii = 1'b0;
        settle();
    endtask

    task automatic test_back_to_back();
        int mm;
        clear_log(); mii = 1'b0;
        build(60, 0, 1, 0); send(1);
        build(61, 8'h80, 1, 0); send(1); settle();
        mm = 0;
        for (int i = 0; i < bd.size(); i++) begin
            if (i < 60) begin if (bd[i] !== 8'(i)) mm++; end
            else begin if (bd[i] !== 8'(8'h80 + i - 60)) mm++; end
        end
        checks++; if (bd.size() !== 121 || mm !== 0) begin errors++; $display("FAIL b2b_data got n=%0d mm=%0d want n=121 mm=0", bd.size(), mm); end
        checks++; if (n_last !== 2 || n_good !== 2 || n_bad !== 0 || last_pos !== 120 || stray !== 0) begin errors++; $display("FAIL b2b_frames got l=%0d g=%0d b=%0d pos=%0d s=%0d want 2 2 0 120 0", n_last, n_good, n_bad, last_pos, stray); end
    endtask

    task automatic test_reset_mid_frame();
        build(60, 0, 1, 0);
        for (int i = 0; i < 8 + 20; i++) begin
            @(negedge clk);
            rx_dv = 1'b1; rx_data = tx[i]; rx_er = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1; rx_data = tx[28];
        @(negedge clk);
        checks++;
        if ({tdata, tvalid, tlast, tuser, fgood, fbad} !== 13'd0) begin
            errors++; $display("FAIL midreset_outputs got %h want 0", {tdata, tvalid, tlast, tuser, fgood, fbad});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        for (int i = 29; i < tx.size(); i++) begin
            @(negedge clk);
            rx_dv = 1'b1; rx_data = tx[i];
        end
        @(negedge clk);
        rx_dv = 1'b0; rx_data = 8'd0;
        settle();
        checks++; if (bd.size() !== 0 || n_last !== 0 || n_good + n_bad !== 0) begin errors++; $display("FAIL midreset_no_tlast got beats=%0d last=%0d pulses=%0d want 0 0 0", bd.size(), n_last, n_good + n_bad); end
        clear_log();
        build(60, 0, 1, 0); send(1); settle();
        checks++; if (bd.size() !== 60 || n_good !== 1 || last_pos !== 59 || last_user !== 1'b0) begin errors++; $display("FAIL after_reset_good got n=%0d g=%0d pos=%0d u=%b want 60 1 59 0", bd.size(), n_good, last_pos, last_user); end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_good_gmii();
        test_bad_fcs();
        test_runt();
        test_errors();
        test_mii();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_mac.md
# rx_mac

Receive half of the Ethernet MAC. Consumes the byte stream from the RGMII layer, strips the preamble and SFD, and checks the CRC-32 FCS and minimum frame length. Forwards the frame payload, with the FCS removed, as an AXI-Stream to the RX FIFO. `tlast` marks the final payload byte, and `tuser` flags a bad frame so the FIFO can drop it.

## Interface
Parameters:
- `MIN_FRAME`, 64: minimum legal length in bytes from the first byte after SFD through the FCS, inclusive.

Ports:
- `clk`  in  1  MAC clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rgmii_mac_rx_data`  in  8  received byte.
- `rgmii_mac_rx_dv`  in  1  frame-valid; high for the whole frame, including the preamble.
- `rgmii_mac_rx_er`  in  1  PHY-reported error on the current byte.
- `mii_select`  in  1  1 = MII (10/100): a byte is valid only on alternate dv-high cycles; 0 = GMII: every dv-high cycle carries a byte.
- `m_rx_axis_tdata`  out  8  payload byte.
- `m_rx_axis_tvalid`  out  1  one-cycle strobe per payload byte; there is no backpressure.
- `m_rx_axis_tlast`  out  1  qualifies the final payload byte.
- `m_rx_axis_tuser`  out  1  bad frame; valid only with `tlast`.
- `rx_frame_good`  out  1  one-cycle pulse, coincident with a `tlast` beat that has `tuser` = 0.
- `rx_frame_bad`  out  1  one-cycle pulse, coincident with a `tlast` beat that has `tuser` = 1.

## Operation
- Byte qualifier:
  - GMII: every cycle with dv = 1.
  - MII: the first dv-high cycle of a frame, then every second cycle while dv stays high. An internal phase toggle is cleared whenever dv = 0.
- States:
  - IDLE: wait for dv = 1, then go to PREAMBLE. A frame always starts with dv rising from 0.
  - PREAMBLE:
    - 0x55 stays in PREAMBLE.
    - 0xD5 (SFD) goes to PAYLOAD, resetting the CRC to 0xFFFFFFFF and the byte count to 0.
    - Any other byte, or er = 1, goes to DROP.
    - dv = 0 goes to IDLE.
    - Nothing is output from this state.
  - PAYLOAD: each qualified byte is fed into the CRC and pushed into a 5-byte delay line. The count saturates at 2047. er = 1 sets a sticky error flag. On the first cycle with dv = 0, go to IDLE and finalise the frame.
  - DROP: wait for dv = 0, then go to IDLE. No output.
- CRC:
  - Reflected polynomial 0xEDB88320, byte-wide, LSB first.
  - Runs over all bytes after the SFD, including the FCS.
  - The frame passes when the final register equals 0xDEBB20E3.
- Delay line: a push while it already holds 5 bytes emits the oldest byte (tvalid = 1, tlast = 0). The delay line therefore always withholds the FCS plus one payload byte.
- Finalise, on the first dv = 0 cycle after PAYLOAD:
  - Count ≥ 5: emit the remaining oldest byte (the last payload byte) with tlast = 1.
    - tuser = sticky_er OR (count < MIN_FRAME) OR CRC mismatch.
    - Pulse `rx_frame_good` or `rx_frame_bad` accordingly.
  - Count < 5: emit nothing; the frame is silently discarded.
  - In both cases, clear the delay line and the error flag.
- Reset: state goes to IDLE, the delay line is cleared, and all outputs go to 0. If dv is already high when reset releases, the block enters DROP until dv = 0, so a partial frame is never forwarded.

## Timing
- Reset value of every output: 0.
- All outputs are registered.
- A payload byte sampled at edge N is emitted (tvalid = 1) in the cycle after edge M, where M is the edge that samples the payload byte five positions later.
- The tlast beat appears in the cycle after the edge that first samples dv = 0.
- GMII: tvalid is continuous during the body of the frame. MII: tvalid is high every second cycle.
- An inter-frame gap of one dv = 0 cycle is sufficient. The tlast beat of frame k and the first PREAMBLE sample of frame k+1 may overlap.
- tlast, tuser, and the good/bad pulses occur only with tvalid = 1.

## Test plan
- GMII, 7×0x55 + 0xD5, payload 0x00..0x3B (60 bytes) plus correct FCS -> 60 beats 0x00..0x3B; tlast on 0x3B; tuser = 0; one `rx_frame_good` pulse. No FCS byte appears on the output.
- Same frame with FCS bit 0 flipped -> identical 60 beats; tuser = 1 on 0x3B; `rx_frame_bad` pulse.
- Runt: 16-byte payload + correct FCS -> 16 beats; tuser = 1. Then a 3-byte post-SFD frame -> no tvalid at all.
- er pulsed on payload byte 30 of the 60-byte frame -> all 60 beats delivered; tuser = 1. Separately, er during the preamble, or a preamble byte 0x5D -> no output; the next good frame is received normally.
- MII mode, the 60-byte good frame with dv held high -> tvalid is exactly every 2nd cycle; data is identical to the first case; tuser = 0.
- Two back-to-back frames with a 1-cycle gap -> both received correctly. Reset asserted mid-payload of a third frame with dv still high -> outputs 0; no tlast for that frame; the next frame is received correctly.
